sdram_chip_model: RTL and testbench
===================================

// Module: sdram_chip_model
// PURPOSE
//   Synthesizable responder for the single-access SDRAM command bus driven by the
//   CPC memory controller. Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows,
//   stores 16-bit words in on-chip RAM and returns read data after the programmed CAS
//   latency. Used in loopback test builds and benches in place of the MT48LC16M16.
// PARAMETERS
//   ROW_BITS   4    low row-address bits stored; higher row bits are ignored (aliased)
//   COL_BITS   9    column bits stored (column = A[8:0])
//   TRCD       2    min cycles from ACTIVE to READ/WRITE on the same bank
// PORTS
//   clk        in   1    memory clock; all inputs are sampled on its rising edge
//   reset      in   1    synchronous, active-high
//   SDRAM_CKE  in   1    clock enable; when low, commands are ignored
//   SDRAM_nCS  in   1    chip select, active low
//   SDRAM_nRAS in   1    row address strobe, active low
//   SDRAM_nCAS in   1    column address strobe, active low
//   SDRAM_nWE  in   1    write enable, active low
//   SDRAM_BA   in   2    bank address
//   SDRAM_A    in   13   row address, or {A10 = auto-precharge, A[8:0] = column}
//   SDRAM_DQML in   1    write mask for bits [7:0], active high
//   SDRAM_DQMH in   1    write mask for bits [15:8], active high
//   dq_in      in   16   write data from the controller
//   dq_out     out  16   read data
//   dq_oe      out  1    high while dq_out is driven
//   mode_reg   out  13   last LOAD_MODE value
//   mode_valid out  1    a legal LOAD_MODE has been accepted
//   refresh_cnt out 16   AUTO_REFRESH count; wraps at 0xFFFF
//   err        out  1    sticky protocol-violation flag
//   err_code   out  3    code of the first violation
// BEHAVIOUR
//   Reset: all banks closed; mode_valid = 0; mode_reg = 0; dq_oe = 0; dq_out = 0;
//     refresh_cnt = 0; err = 0; err_code = 0; read pipe flushed. RAM contents are kept.
//   Decode: {nCS,nRAS,nCAS,nWE} is decoded only when CKE = 1 and nCS = 0:
//     0011 ACT, 0101 RD, 0100 WR, 0010 PRE, 0001 REF, 0000 LMR;
//     NOP (0111) and burst-terminate (0110) do nothing.
//   Per-bank state: IDLE -> ACTIVE(row, age) on ACT. Age counts up, saturating at TRCD.
//     ACTIVE -> IDLE on PRE (A10 = 1 closes all banks; otherwise closes bank BA), or on
//     the edge after a RD/WR with A10 = 1.
//   Storage address: {BA, row[ROW_BITS-1:0], A[COL_BITS-1:0]}.
//   LMR: accepted only when all banks are IDLE. Latches mode_reg = A and sets mode_valid.
//     CL = A[6:4] must be 2 or 3, and burst length A[2:0] must be 000; otherwise
//     err code 1 is raised and mode_valid is left unchanged.
//   WR at edge T:
//     - dq_in is sampled at T.
//     - Byte lanes are written unless masked by DQML/DQMH.
//     - Data is visible to a RD issued at T+1.
//   RD at edge T:
//     - dq_out holds the word and dq_oe = 1 for exactly one cycle, so the data is
//       stable across edge T+CL.
//     - DQM is ignored on reads.
//     - A new RD every cycle is allowed; the pipeline is CL deep.
//   CKE low: command decode is suppressed, but the read pipeline keeps advancing.
//   REF: increments refresh_cnt. Requires all banks IDLE.
//   Error codes (first error is captured; err stays set until reset):
//     1  illegal LMR
//     2  RD/WR before mode_valid
//     3  RD/WR to an IDLE bank
//     4  ACT to an ACTIVE bank
//     5  RD/WR issued with age < TRCD
//     6  REF or LMR while any bank is ACTIVE
//     7  WR issued while dq_oe = 1 (bus contention)
//   Erroneous commands have no side effect, except that RD/WR with code 5 still executes.
//   Simultaneous events: PRE and ACT to different banks on consecutive edges are legal.
//     An auto-precharge close and an ACT on the next edge to the same bank are legal.
//   Reset mid-read: any pending dq_oe is cancelled on the reset edge.
// TESTING
//   1. Init sequence PRE(A10 = 1), LMR 0x220 -> mode_valid = 1, CL = 2, err = 0.
//   2. ACT bank 1 row 5; WR at +2 (col 0x12, A10 = 1, dq_in 0xBEEF, DQM 00);
//      ACT, then RD at +2 -> dq_out = 0xBEEF, dq_oe high at RD+2 only.
//   3. WR 0x1234 then WR 0xAB56 with DQMH = 1 to the same address;
//      RD -> 0x1256 (byte masking).
//   4. LMR CL = 3 (0x230); RD issued -> data on edge T+3; back-to-back RDs on T and
//      T+1 -> two consecutive dq_oe cycles.
//   5. RD one cycle after ACT -> err = 1, err_code = 5; a later RD to an IDLE bank
//      leaves err_code = 5.
//   6. REF while bank 2 is ACTIVE -> err_code 6, refresh_cnt unchanged;
//      reset mid-RD -> dq_oe = 0 on the next cycle, all outputs at reset values.

Source files
------------

// File: rtl/sdram_chip_model.sv
// SDRAM command-bus responder: decodes ACT/RD/WR/PRE/REF/LMR, tracks per-bank
// open rows with an ACT-to-CAS age, stores 16-bit words in on-chip RAM and
// returns read data after the programmed CAS latency (2 or 3).
module sdram_chip_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 9,
    parameter int TRCD     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [1:0]  SDRAM_BA,
    input  logic [12:0] SDRAM_A,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [12:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] refresh_cnt,
    output logic        err,
    output logic [2:0]  err_code
);
    localparam int ADDR_W = 2 + ROW_BITS + COL_BITS;
    localparam int AGE_W  = (TRCD < 1) ? 1 : $clog2(TRCD + 1);

    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    logic [15:0]         mem [2**ADDR_W];
    logic [15:0]         ram_rd_q;

    logic [3:0]          bank_active_q, bank_active_d;
    logic [ROW_BITS-1:0] row_q [4];
    logic [ROW_BITS-1:0] row_d [4];
    logic [AGE_W-1:0]    age_q [4];
    logic [AGE_W-1:0]    age_d [4];
    logic [12:0]         mode_reg_q, mode_reg_d;
    logic                mode_valid_q, mode_valid_d;
    logic [15:0]         refresh_q, refresh_d;
    logic                err_q, err_d;
    logic [2:0]          err_code_q, err_code_d;
    logic                p0_vld_q, p0_vld_d;
    logic                p1_vld_q, p1_vld_d;
    logic [15:0]         p1_data_q, p1_data_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         dq_out_q, dq_out_d;

    logic [3:0]          cmd;
    logic                cmd_en;
    logic                sel_active;
    logic                lmr_ok;
    logic                cl3;
    logic [2:0]          err_new;
    logic                rd_go, wr_go;
    logic [ADDR_W-1:0]   ram_addr;

    assign cmd        = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    assign cmd_en     = SDRAM_CKE & ~SDRAM_nCS;
    assign sel_active = bank_active_q[SDRAM_BA];
    assign lmr_ok     = ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) &&
                        (SDRAM_A[2:0] == 3'd0);
    assign cl3        = (mode_reg_q[6:4] == 3'd3);
    assign ram_addr   = {SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[COL_BITS-1:0]};

    // Command decode, bank bookkeeping, error capture and read-pipe advance
    always_comb begin
        bank_active_d = bank_active_q;
        row_d         = row_q;
        age_d         = age_q;
        mode_reg_d    = mode_reg_q;
        mode_valid_d  = mode_valid_q;
        refresh_d     = refresh_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        err_new       = 3'd0;
        rd_go         = 1'b0;
        wr_go         = 1'b0;

        for (int b = 0; b < 4; b++) begin
            if (bank_active_q[b] && (age_q[b] < AGE_W'(TRCD)))
                age_d[b] = age_q[b] + AGE_W'(1);
        end

        if (cmd_en) begin
            case (cmd)
                CMD_ACT: begin
                    if (sel_active) begin
                        err_new = 3'd4;
                    end else begin
                        bank_active_d[SDRAM_BA] = 1'b1;
                        row_d[SDRAM_BA]         = SDRAM_A[ROW_BITS-1:0];
                        // One cycle has elapsed by the time the next edge samples a command
                        age_d[SDRAM_BA]         = AGE_W'(1);
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!mode_valid_q) begin
                        err_new = 3'd2;
                    end else if (!sel_active) begin
                        err_new = 3'd3;
                    end else if ((cmd == CMD_WR) && dq_oe_q) begin
                        err_new = 3'd7;
                    end else begin
                        // A tRCD violation is flagged but the access still happens
                        if (age_q[SDRAM_BA] < AGE_W'(TRCD)) err_new = 3'd5;
                        rd_go = (cmd == CMD_RD);
                        wr_go = (cmd == CMD_WR);
                        if (SDRAM_A[10]) bank_active_d[SDRAM_BA] = 1'b0;
                    end
                end
                CMD_PRE: begin
                    if (SDRAM_A[10]) bank_active_d = 4'b0000;
                    else             bank_active_d[SDRAM_BA] = 1'b0;
                end
                CMD_REF: begin
                    if (|bank_active_q) err_new = 3'd6;
                    else                refresh_d = refresh_q + 16'd1;
                end
                CMD_LMR: begin
                    if (|bank_active_q) begin
                        err_new = 3'd6;
                    end else if (!lmr_ok) begin
                        err_new = 3'd1;
                    end else begin
                        mode_reg_d   = SDRAM_A;
                        mode_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if ((err_new != 3'd0) && !err_q) begin
            err_d      = 1'b1;
            err_code_d = err_new;
        end

        p0_vld_d  = rd_go;
        p1_vld_d  = p0_vld_q;
        p1_data_d = ram_rd_q;
        if (cl3) begin
            dq_oe_d  = p1_vld_q;
            dq_out_d = p1_vld_q ? p1_data_q : 16'h0000;
        end else begin
            dq_oe_d  = p0_vld_q;
            dq_out_d = p0_vld_q ? ram_rd_q : 16'h0000;
        end
    end

    // Word storage with byte-lane masks and a registered read port; never reset
    always_ff @(posedge clk) begin
        if (wr_go && !SDRAM_DQML) mem[ram_addr][7:0]  <= dq_in[7:0];
        if (wr_go && !SDRAM_DQMH) mem[ram_addr][15:8] <= dq_in[15:8];
        ram_rd_q <= mem[ram_addr];
    end

    // Row/age and pipeline data need no reset: bank_active and valids gate them
    always_ff @(posedge clk) begin
        row_q     <= row_d;
        age_q     <= age_d;
        p1_data_q <= p1_data_d;
    end

    // Control state with synchronous reset; reset also cancels any pending read
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_active_q <= 4'b0000;
            mode_reg_q    <= 13'h0;
            mode_valid_q  <= 1'b0;
            refresh_q     <= 16'h0;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            p0_vld_q      <= 1'b0;
            p1_vld_q      <= 1'b0;
            dq_oe_q       <= 1'b0;
            dq_out_q      <= 16'h0;
        end else begin
            bank_active_q <= bank_active_d;
            mode_reg_q    <= mode_reg_d;
            mode_valid_q  <= mode_valid_d;
            refresh_q     <= refresh_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            p0_vld_q      <= p0_vld_d;
            p1_vld_q      <= p1_vld_d;
            dq_oe_q       <= dq_oe_d;
            dq_out_q      <= dq_out_d;
        end
    end

    assign dq_out      = dq_out_q;
    assign dq_oe       = dq_oe_q;
    assign mode_reg    = mode_reg_q;
    assign mode_valid  = mode_valid_q;
    assign refresh_cnt = refresh_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_sdram_chip_model.sv
// Directed bench for sdram_chip_model: init, write/read, byte masks, CAS
// latency 2 and 3, protocol errors, refresh, CKE gating and reset mid-read.
module tb_sdram_chip_model;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] NOP = 4'b0111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cke = 1'b1;
    logic [3:0]  cmd = NOP;
    logic [1:0]  ba = 2'd0;
    logic [12:0] addr = 13'h0;
    logic        dqml = 1'b0;
    logic        dqmh = 1'b0;
    logic [15:0] dq_in = 16'h0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    int n_checks = 0;
    int n_errors = 0;

    sdram_chip_model dut (
        .clk        (clk),
        .reset      (reset),
        .SDRAM_CKE  (cke),
        .SDRAM_nCS  (cmd[3]),
        .SDRAM_nRAS (cmd[2]),
        .SDRAM_nCAS (cmd[1]),
        .SDRAM_nWE  (cmd[0]),
        .SDRAM_BA   (ba),
        .SDRAM_A    (addr),
        .SDRAM_DQML (dqml),
        .SDRAM_DQMH (dqmh),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .mode_reg   (mode_reg),
        .mode_valid (mode_valid),
        .refresh_cnt(refresh_cnt),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One command on one rising edge; returns 1 time unit after that edge
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d, input logic ml, input logic mh);
        @(negedge clk);
        cmd = c; ba = b; addr = a; dq_in = d; dqml = ml; dqmh = mh;
        @(posedge clk);
        #1;
        cmd = NOP; dqml = 1'b0; dqmh = 1'b0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(NOP, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cmd = NOP;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_oe", {15'h0, dq_oe}, 16'h0);
        chk("rst_dq", dq_out, 16'h0);
        chk("rst_mv", {15'h0, mode_valid}, 16'h0);
        chk("rst_mr", {3'h0, mode_reg}, 16'h0);
        chk("rst_err", {12'h0, err, err_code}, 16'h0);
        chk("rst_ref", refresh_cnt, 16'h0);

        // 1: init
        issue(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(LMR, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
        chk("init_mv", {15'h0, mode_valid}, 16'h1);
        chk("init_mr", {3'h0, mode_reg}, 16'h0220);
        chk("init_err", {15'h0, err}, 16'h0);

        // 2: write with auto-precharge, re-open same bank next edge, read CL2
        issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        nop(1);
        issue(WR, 2'd1, 13'h412, 16'hBEEF, 1'b0, 1'b0);
        issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        nop(1);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
        chk("cl2_oe_t1", {15'h0, dq_oe}, 16'h0);
        nop(1);
        chk("cl2_oe_t2", {15'h0, dq_oe}, 16'h1);
        chk("cl2_data", dq_out, 16'hBEEF);
        nop(1);
        chk("cl2_oe_t3", {15'h0, dq_oe}, 16'h0);
        chk("ap_err", {12'h0, err, err_code}, 16'h0);

        // 3: byte masks
        issue(WR, 2'd1, 13'h012, 16'h1234, 1'b0, 1'b0);
        issue(WR, 2'd1, 13'h012, 16'hAB56, 1'b0, 1'b1);
        issue(WR, 2'd1, 13'h013, 16'h1111, 1'b0, 1'b0);
        issue(WR, 2'd1, 13'h013, 16'h2222, 1'b1, 1'b0);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b1, 1'b1);
        nop(1);
        chk("dqmh_data", dq_out, 16'h1256);
        issue(RD, 2'd1, 13'h013, 16'h0, 1'b0, 1'b0);
        nop(1);
        chk("dqml_data", dq_out, 16'h2211);
        nop(1);

        // 4: CL3 single and back-to-back
        issue(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(LMR, 2'd0, 13'h230, 16'h0, 1'b0, 1'b0);
        chk("cl3_mr", {3'h0, mode_reg}, 16'h0230);
        issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        nop(1);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
        nop(1);
        chk("cl3_oe_t1", {15'h0, dq_oe}, 16'h0);
        nop(1);
        chk("cl3_oe_t2", {15'h0, dq_oe}, 16'h1);
        chk("cl3_data", dq_out, 16'h1256);
        nop(1);
        chk("cl3_oe_t3", {15'h0, dq_oe}, 16'h0);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
        issue(RD, 2'd1, 13'h013, 16'h0, 1'b0, 1'b0);
        chk("b2b_oe0", {15'h0, dq_oe}, 16'h0);
        nop(1);
        chk("b2b_oe1", {15'h0, dq_oe}, 16'h1);
        chk("b2b_d1", dq_out, 16'h1256);
        nop(1);
        chk("b2b_oe2", {15'h0, dq_oe}, 16'h1);
        chk("b2b_d2", dq_out, 16'h2211);
        nop(1);
        chk("b2b_oe3", {15'h0, dq_oe}, 16'h0);
        chk("b2b_err", {15'h0, err}, 16'h0);

        // 5: tRCD violation, then a later error must not overwrite the code
        issue(ACT, 2'd0, 13'd3, 16'h0, 1'b0, 1'b0);
        issue(RD, 2'd0, 13'h001, 16'h0, 1'b0, 1'b0);
        chk("trcd_err", {12'h0, err, err_code}, 16'h000D);
        nop(3);
        issue(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(RD, 2'd2, 13'h001, 16'h0, 1'b0, 1'b0);
        chk("sticky_err", {12'h0, err, err_code}, 16'h000D);

        // 6: refresh, CKE gating, REF with an active bank
        do_reset();
        chk("rst2_err", {12'h0, err, err_code}, 16'h0);
        cke = 1'b0;
        issue(REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        cke = 1'b1;
        chk("cke_ref", refresh_cnt, 16'h0);
        issue(REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        chk("ref_cnt", refresh_cnt, 16'h1);
        issue(ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
        issue(REF, 2'd0, 13'h0, 16'h0, 1'b0, 1'b0);
        chk("ref_act_err", {12'h0, err, err_code}, 16'h000E);
        chk("ref_act_cnt", refresh_cnt, 16'h1);

        // Reset in the middle of a CL2 read
        issue(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(LMR, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
        issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        nop(1);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
        do_reset();
        chk("mid_oe", {15'h0, dq_oe}, 16'h0);
        chk("mid_dq", dq_out, 16'h0);
        chk("mid_mv", {15'h0, mode_valid}, 16'h0);
        chk("mid_ref", refresh_cnt, 16'h0);
        chk("mid_err", {12'h0, err, err_code}, 16'h0);
        nop(1);
        chk("mid_oe2", {15'h0, dq_oe}, 16'h0);

        // RAM survives reset
        issue(LMR, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
        issue(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        nop(1);
        issue(RD, 2'd1, 13'h012, 16'h0, 1'b0, 1'b0);
        nop(1);
        chk("keep_data", dq_out, 16'h1256);

        // Illegal LMR (CL = 5) leaves mode untouched
        issue(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        issue(LMR, 2'd0, 13'h250, 16'h0, 1'b0, 1'b0);
        chk("lmr_bad_err", {12'h0, err, err_code}, 16'h0009);
        chk("lmr_bad_mr", {3'h0, mode_reg}, 16'h0220);
        chk("lmr_bad_mv", {15'h0, mode_valid}, 16'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
